led_flasher_multi: RTL and testbench

LED_FLASHER_MULTI -- requirements
Module: led_flasher_multi

---
 rtl/led_flasher_multi.sv | 142 ++++++++++++++
 tb/tb_led_flasher_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_flasher_multi.sv
// Multi-channel LED flasher: per channel off / steady / continuous flash / counted burst.
// LED_out and busy are decoded from registered state, one cycle after the enable is sampled.
// No backpressure; each channel follows its own enable and aborts to IDLE when it drops.
module led_flasher_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int HIGH_PERIOD = 600,
  parameter int LOW_PERIOD  = 600,
  parameter int BURST_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          LED_flash,
  input  logic [2*NUM_CH-1:0]        mode,
  input  logic [BURST_W*NUM_CH-1:0]  burst_len,
  output logic [NUM_CH-1:0]          LED_out,
  output logic [NUM_CH-1:0]          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_STEADY = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b11;

  // Terminal counts are compared at counter width; the counter stops at them so never wraps.
  localparam logic [CNT_W-1:0] HI_TC = CNT_W'(HIGH_PERIOD);
  localparam logic [CNT_W-1:0] LO_TC = CNT_W'(LOW_PERIOD);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      state_t               state_q, state_d;
      logic [CNT_W-1:0]     cnt_q, cnt_d;
      logic [BURST_W-1:0]   pulse_q, pulse_d;
      logic [BURST_W-1:0]   blen_q, blen_d;
      logic [1:0]           mode_q, mode_d;
      logic [BURST_W-1:0]   pulse_inc;
      logic                 en;
      logic [1:0]           mode_in;
      logic [BURST_W-1:0]   blen_in;
      logic                 led_c, busy_c;

      assign en      = LED_flash[g];
      assign mode_in = mode[2*g +: 2];
      assign blen_in = burst_len[BURST_W*g +: BURST_W];

      // State, counters and latched activation fields; reset clears everything at once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          pulse_q <= '0;
          blen_q  <= '0;
          mode_q  <= MODE_OFF;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          pulse_q <= pulse_d;
          blen_q  <= blen_d;
          mode_q  <= mode_d;
        end
      end

      // Next-state: enable low always wins, then phase terminal counts per latched mode.
      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = pulse_q;
        blen_d    = blen_q;
        mode_d    = mode_q;
        pulse_inc = pulse_q + BURST_W'(1);
        case (state_q)
          S_IDLE: begin
            cnt_d   = '0;
            pulse_d = '0;
            if (en && (mode_in != MODE_OFF)) begin
              state_d = S_ON;
              mode_d  = mode_in;
              // A zero burst length behaves as a single pulse.
              blen_d  = (blen_in == '0) ? BURST_W'(1) : blen_in;
            end
          end
          S_ON: begin
            if (!en) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              pulse_d = '0;
            end else if (mode_q == MODE_STEADY) begin
              cnt_d = '0;
            end else if (cnt_q == HI_TC) begin
              cnt_d = '0;
              if (mode_q == MODE_BURST) begin
                pulse_d = pulse_inc;
                state_d = (pulse_inc == blen_q) ? S_DONE : S_OFF;
              end else begin
                state_d = S_OFF;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_OFF: begin
            if (!en) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              pulse_d = '0;
            end else if (cnt_q == LO_TC) begin
              state_d = S_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_DONE: begin
            // Burst finished: park until the enable is released so a restart needs a new edge.
            cnt_d = '0;
            if (!en) begin
              state_d = S_IDLE;
              pulse_d = '0;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pulse_d = '0;
          end
        endcase
      end

      // Outputs decoded purely from registered state; steady never enters OFF.
      always_comb begin
        led_c  = (state_q == S_ON);
        busy_c = (state_q == S_ON) || (state_q == S_OFF);
      end

      assign LED_out[g] = led_c;
      assign busy[g]    = busy_c;
    end
  endgenerate

endmodule

// File: tb/tb_led_flasher_multi.sv
// Directed bench for led_flasher_multi with a small timing model per channel.
// Expected outputs are queued as each cycle is stimulated and compared after the edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_led_flasher_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int HP      = 3;
  localparam int LP      = 2;
  localparam int BURST_W = 4;
  localparam int ON_LEN  = HP + 1;
  localparam int PERIOD  = HP + LP + 2;

  localparam int K_IDLE   = 0;
  localparam int K_STEADY = 1;
  localparam int K_FLASH  = 2;
  localparam int K_BURST  = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_CH-1:0]         LED_flash;
  logic [2*NUM_CH-1:0]       mode;
  logic [BURST_W*NUM_CH-1:0] burst_len;
  logic [NUM_CH-1:0]         LED_out;
  logic [NUM_CH-1:0]         busy;

  typedef struct packed {
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] bsy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   kind [NUM_CH];
  int   kcyc [NUM_CH];
  int   blen [NUM_CH];

  led_flasher_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .HIGH_PERIOD(HP), .LOW_PERIOD(LP), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .rst(rst), .LED_flash(LED_flash), .mode(mode),
    .burst_len(burst_len), .LED_out(LED_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {led,busy} for a channel kk cycles after its enable was first sampled.
  function automatic logic [1:0] exp_ch(input int kd, input int kk, input int n);
    int pos, ne, last;
    if (kd == K_IDLE) return 2'b00;
    if (kd == K_STEADY) return 2'b11;
    pos = (kk - 1) % PERIOD;
    if (kd == K_FLASH) return {(pos < ON_LEN), 1'b1};
    ne   = (n == 0) ? 1 : n;
    last = PERIOD * ne - (LP + 1);
    if (kk > last) return 2'b00;
    return {(pos < ON_LEN), 1'b1};
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (LED_out === e.led) else begin
      failures++;
      $error("FAIL %s LED_out: got %b expected %b", tag, LED_out, e.led);
    end
    checks++;
    assert (busy === e.bsy) else begin
      failures++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, e.bsy);
    end
  endtask

  task automatic check_now(input string tag, input logic [NUM_CH-1:0] led, input logic [NUM_CH-1:0] bsy);
    exp_t e;
    e.led = led;
    e.bsy = bsy;
    sb.push_back(e);
    compare(tag);
  endtask

  // Advance the model one cycle, queue its prediction, clock the DUT, then compare.
  task automatic cycle(input string tag);
    exp_t e;
    logic [1:0] r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (kind[c] != K_IDLE) kcyc[c]++;
      r = exp_ch(kind[c], kcyc[c], blen[c]);
      e.led[c] = r[1];
      e.bsy[c] = r[0];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic start(input int ch, input logic [1:0] md, input logic [BURST_W-1:0] bl, input int kd);
    LED_flash[ch]                  = 1'b1;
    mode[2*ch +: 2]                = md;
    burst_len[BURST_W*ch +: BURST_W] = bl;
    kind[ch] = kd;
    kcyc[ch] = 0;
    blen[ch] = int'(bl);
  endtask

  task automatic stop(input int ch);
    LED_flash[ch] = 1'b0;
    kind[ch]      = K_IDLE;
    kcyc[ch]      = 0;
  endtask

  initial begin
    rst       = 1'b1;
    LED_flash = '0;
    mode      = '0;
    burst_len = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      kind[c] = K_IDLE;
      kcyc[c] = 0;
      blen[c] = 0;
    end
    #2;
    check_now("reset", 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_now("post_reset", 4'b0000, 4'b0000);
    cycle("idle");

    // ch0 flash alongside ch3 steady; later mode changes must be ignored.
    start(0, 2'b10, 4'd0, K_FLASH);
    start(3, 2'b01, 4'd0, K_STEADY);
    repeat (10) cycle("flash_steady");
    mode[7:6] = 2'b10;
    mode[1:0] = 2'b01;
    repeat (10) cycle("mode_latch");
    stop(0);
    stop(3);
    repeat (2) cycle("stop_all");

    // Drop enable on the last ON cycle of the first flash pulse.
    start(0, 2'b10, 4'd0, K_FLASH);
    repeat (ON_LEN) cycle("abort_on");
    stop(0);
    repeat (4) cycle("abort");

    // Burst of 2 on ch1 and burst length 0 on ch2; edits while active are ignored.
    start(1, 2'b11, 4'd2, K_BURST);
    start(2, 2'b11, 4'd0, K_BURST);
    repeat (5) cycle("burst");
    burst_len[7:4] = 4'd5;
    mode[3:2]      = 2'b10;
    repeat (12) cycle("burst_done");
    stop(1);
    cycle("burst_release");
    start(1, 2'b11, 4'd2, K_BURST);
    repeat (13) cycle("burst_again");
    stop(1);
    stop(2);
    cycle("burst_stop");

    // Enable high with mode off stays idle.
    LED_flash[0] = 1'b1;
    mode[1:0]    = 2'b00;
    repeat (3) cycle("mode_off");
    stop(0);
    cycle("mode_off_stop");

    // All channels ON, then an asynchronous reset between edges.
    for (int c = 0; c < NUM_CH; c++) start(c, 2'b01, 4'd0, K_STEADY);
    repeat (2) cycle("all_on");
    #3;
    rst = 1'b1;
    #1;
    check_now("async_rst", 4'b0000, 4'b0000);
    for (int c = 0; c < NUM_CH; c++) begin
      kind[c] = K_IDLE;
      kcyc[c] = 0;
    end
    repeat (2) cycle("rst_hold");
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      kind[c] = K_STEADY;
      kcyc[c] = 0;
    end
    repeat (3) cycle("rst_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
